// File: rtl/instr_strir_if.sv
// Memory request/done bus shared by the execute-stage load and store units.
interface instr_strir_if;
    logic [15:0] memory_address;
    logic [15:0] memory_wdata;
    logic        memory_write;
    logic        memory_request;
    logic [15:0] memory_data;
    logic        memory_done;

    modport master (
        output memory_address,
        output memory_wdata,
        output memory_write,
        output memory_request,
        input  memory_data,
        input  memory_done
    );

    modport slave (
        input  memory_address,
        input  memory_wdata,
        input  memory_write,
        input  memory_request,
        output memory_data,
        output memory_done
    );
endinterface

// File: rtl/instr_strir.sv
// Register-indirect store executor: word store is one write; byte store is a
// read-modify-write into the big-endian byte lane selected by address bit 0.
module instr_strir (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  strir,
    input  logic                  strirb,
    input  logic [15:0]           operand,
    input  logic [15:0]           regbus2,
    input  logic [15:0]           regbus1,
    output logic                  executeBusy,
    instr_strir_if.master         mem
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        WR      = 5'b00010,
        RD_B    = 5'b00100,
        MERGE_B = 5'b01000,
        WR_B    = 5'b10000
    } state_e;

    state_e              state_q,   state_d;
    logic                busy_q,    busy_d;
    logic                req_q,     req_d;
    logic                write_q,   write_d;
    logic [DATA_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   merge_q,   merge_d;
    logic [BYTE_W-1:0]   byte_q,    byte_d;
    logic                lane_q,    lane_d;

    logic [DATA_W-1:0]   addr_c;
    logic [DATA_W-1:0]   merged_c;

    assign addr_c = DATA_W'(operand + regbus2);

    // Lane 0 (even address) is the upper byte.
    assign merged_c = lane_q ? {merge_q[DATA_W-1:BYTE_W], byte_q}
                             : {byte_q, merge_q[BYTE_W-1:0]};

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        req_d   = req_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        byte_d  = byte_q;
        lane_d  = lane_q;

        unique case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                req_d   = 1'b0;
                write_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                if (strir) begin
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    write_d = 1'b1;
                    addr_d  = addr_c;
                    wdata_d = regbus1;
                    state_d = WR;
                end else if (strirb) begin
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    write_d = 1'b0;
                    addr_d  = addr_c;
                    byte_d  = regbus1[BYTE_W-1:0];
                    lane_d  = addr_c[0];
                    state_d = RD_B;
                end
            end
            WR, WR_B: begin
                if (mem.memory_done) begin
                    busy_d  = 1'b0;
                    req_d   = 1'b0;
                    write_d = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = IDLE;
                end
            end
            RD_B: begin
                if (mem.memory_done) begin
                    merge_d = mem.memory_data;
                    req_d   = 1'b0;
                    state_d = MERGE_B;
                end
            end
            MERGE_B: begin
                req_d   = 1'b1;
                write_d = 1'b1;
                wdata_d = merged_c;
                state_d = WR_B;
            end
            default: begin
                busy_d  = 1'b0;
                req_d   = 1'b0;
                write_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            byte_q  <= '0;
            lane_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
        end
    end

    assign executeBusy        = busy_q;
    assign mem.memory_request = req_q;
    assign mem.memory_write   = write_q;
    assign mem.memory_address = addr_q;
    assign mem.memory_wdata   = wdata_q;
endmodule

// File: tb/tb_instr_strir.sv
// Directed bench for instr_strir: word, byte-lane, wrap/priority, ignored inputs, async reset.
module tb_instr_strir;
    logic        clk = 1'b0;
    logic        reset;
    logic        strir;
    logic        strirb;
    logic [15:0] operand;
    logic [15:0] regbus2;
    logic [15:0] regbus1;
    logic        executeBusy;

    int checks   = 0;
    int failures = 0;

    instr_strir_if mem_if ();

    instr_strir dut (
        .clk         (clk),
        .reset       (reset),
        .strir       (strir),
        .strirb      (strirb),
        .operand     (operand),
        .regbus2     (regbus2),
        .regbus1     (regbus1),
        .executeBusy (executeBusy),
        .mem         (mem_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [15:0] data);
        mem_if.memory_data = data;
        mem_if.memory_done = 1'b1;
        cycle();
        mem_if.memory_done = 1'b0;
        mem_if.memory_data = 16'h0000;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(executeBusy), 32'd0);
        check({tag, "_req"},   32'(mem_if.memory_request), 32'd0);
        check({tag, "_write"}, 32'(mem_if.memory_write), 32'd0);
        check({tag, "_addr"},  32'(mem_if.memory_address), 32'd0);
        check({tag, "_wdata"}, 32'(mem_if.memory_wdata), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        strir   = 1'b0;
        strirb  = 1'b0;
        operand = 16'h0000;
        regbus2 = 16'h0000;
        regbus1 = 16'h0000;
        mem_if.memory_data = 16'h0000;
        mem_if.memory_done = 1'b0;
        cycle();
        cycle();
        check_idle("rst");
        reset = 1'b0;
        cycle();
        check_idle("post_rst");

        // Word store
        operand = 16'h0010; regbus2 = 16'h1000; regbus1 = 16'hBEEF; strir = 1'b1;
        cycle();
        strir = 1'b0;
        regbus1 = 16'h0000;
        operand = 16'h7777;
        check("w_busy",  32'(executeBusy), 32'd1);
        check("w_req",   32'(mem_if.memory_request), 32'd1);
        check("w_write", 32'(mem_if.memory_write), 32'd1);
        check("w_addr",  32'(mem_if.memory_address), 32'h1010);
        check("w_wdata", 32'(mem_if.memory_wdata), 32'hBEEF);
        cycle();
        cycle();
        check("w_hold_req",   32'(mem_if.memory_request), 32'd1);
        check("w_hold_wdata", 32'(mem_if.memory_wdata), 32'hBEEF);
        pulse_done(16'h0000);
        check_idle("w_done");

        // Upper-byte store
        operand = 16'h2000; regbus2 = 16'h0000; regbus1 = 16'h00AA; strirb = 1'b1;
        cycle();
        strirb = 1'b0;
        check("ub_rd_req",   32'(mem_if.memory_request), 32'd1);
        check("ub_rd_write", 32'(mem_if.memory_write), 32'd0);
        check("ub_rd_addr",  32'(mem_if.memory_address), 32'h2000);
        check("ub_rd_busy",  32'(executeBusy), 32'd1);
        cycle();
        pulse_done(16'h1234);
        check("ub_gap_req",  32'(mem_if.memory_request), 32'd0);
        check("ub_gap_busy", 32'(executeBusy), 32'd1);
        cycle();
        check("ub_wr_req",   32'(mem_if.memory_request), 32'd1);
        check("ub_wr_write", 32'(mem_if.memory_write), 32'd1);
        check("ub_wr_addr",  32'(mem_if.memory_address), 32'h2000);
        check("ub_wr_wdata", 32'(mem_if.memory_wdata), 32'hAA34);
        pulse_done(16'h0000);
        check_idle("ub_done");

        // Lower-byte store, with a stray strir during the write phase
        operand = 16'h2000; regbus2 = 16'h0001; regbus1 = 16'hFF55; strirb = 1'b1;
        cycle();
        strirb = 1'b0;
        check("lb_rd_addr",  32'(mem_if.memory_address), 32'h2001);
        check("lb_rd_write", 32'(mem_if.memory_write), 32'd0);
        pulse_done(16'h1234);
        check("lb_gap_req",  32'(mem_if.memory_request), 32'd0);
        cycle();
        check("lb_wr_addr",  32'(mem_if.memory_address), 32'h2001);
        check("lb_wr_wdata", 32'(mem_if.memory_wdata), 32'h1255);
        strir = 1'b1; regbus1 = 16'h0BAD;
        cycle();
        strir = 1'b0;
        check("lb_ign_wdata", 32'(mem_if.memory_wdata), 32'h1255);
        check("lb_ign_write", 32'(mem_if.memory_write), 32'd1);
        pulse_done(16'h0000);
        check_idle("lb_done");
        pulse_done(16'hFFFF);
        check_idle("idle_done");
        cycle();
        check_idle("idle_done2");

        // Address wrap and strir priority over strirb
        operand = 16'hFFFF; regbus2 = 16'h0002; regbus1 = 16'h5A5A;
        strir = 1'b1; strirb = 1'b1;
        cycle();
        strir = 1'b0; strirb = 1'b0;
        check("wp_write", 32'(mem_if.memory_write), 32'd1);
        check("wp_addr",  32'(mem_if.memory_address), 32'h0001);
        check("wp_wdata", 32'(mem_if.memory_wdata), 32'h5A5A);
        pulse_done(16'h0000);
        check_idle("wp_done");
        cycle();
        check("wp_no_rd", 32'(mem_if.memory_request), 32'd0);

        // Asynchronous reset during a word write
        operand = 16'h0100; regbus2 = 16'h0020; regbus1 = 16'hC0DE; strir = 1'b1;
        cycle();
        strir = 1'b0;
        check("ar_req_before", 32'(mem_if.memory_request), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("ar_async");
        @(negedge clk);
        reset = 1'b0;
        cycle();
        cycle();
        check_idle("ar_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
